// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Program-flow controller for the MiniAlu core. It addresses the combinational
// instruction ROM, registers the fetched word toward the execute datapath and
// resolves the control opcodes locally:
//   NOP - delay for N cycles (N = word[23:0])
//   JMP - unconditional jump to zero-extended word[23:16], never issued
//   BLE - issued to the datapath, then waits one cycle for its compare result
//
// Ports
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous active-high reset
//   oAddress      out  ROM address (current program counter)
//   iInstruction  in   ROM word for oAddress, valid in the same cycle
//   oInstruction  out  registered instruction issued to the datapath
//   oValid        out  oInstruction is new this cycle (execute exactly once)
//   iBranchTaken  in   compare result for the issued BLE (1 = src1 <= src0)
//   iStall        in   datapath busy; freezes the sequencer
//   oBusy         out  high while in DELAY or BRANCH
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DELAY_WIDTH = 24
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [27:0]           iInstruction,
    output logic [27:0]           oInstruction,
    output logic                  oValid,
    input  logic                  iBranchTaken,
    input  logic                  iStall,
    output logic                  oBusy
);

    // Control opcode encodings shared with the rest of the MiniAlu core.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_BLE = 4'd2;
    localparam logic [3:0] OP_JMP = 4'd5;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DELAY  = 2'd1,
        S_BRANCH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [27:0]            r_instr;
    logic                   r_valid;
    logic                   r_busy;
    logic [DELAY_WIDTH-1:0] r_count;

    logic [3:0]             w_opcode;
    logic [DELAY_WIDTH-1:0] w_delay;
    logic [ADDR_WIDTH-1:0]  w_pc_inc;
    logic [ADDR_WIDTH-1:0]  w_jump_target;
    logic [ADDR_WIDTH-1:0]  w_branch_target;

    assign w_opcode        = iInstruction[27:24];
    assign w_delay         = DELAY_WIDTH'(iInstruction[23:0]);
    // Natural wrap of the adder gives the modulo-2^ADDR_WIDTH PC behaviour.
    assign w_pc_inc        = r_pc + ADDR_WIDTH'(1);
    assign w_jump_target   = ADDR_WIDTH'(iInstruction[23:16]);
    // While in BRANCH the issued BLE is still held in r_instr, so its target
    // is taken from there rather than from the ROM port.
    assign w_branch_target = ADDR_WIDTH'(r_instr[23:16]);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (iStall) begin
            // Freeze everything; only the issue strobe drops so the held
            // instruction is never executed a second time.
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    case (w_opcode)
                        OP_JMP: begin
                            // Resolved here; the datapath never sees it.
                            r_valid <= 1'b0;
                            r_pc    <= w_jump_target;
                        end
                        OP_BLE: begin
                            // PC holds until the compare result comes back.
                            r_instr <= iInstruction;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_BRANCH;
                        end
                        OP_NOP: begin
                            r_instr <= iInstruction;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_inc;
                            if (w_delay != '0) begin
                                r_count <= w_delay;
                                r_busy  <= 1'b1;
                                r_state <= S_DELAY;
                            end
                        end
                        default: begin
                            r_instr <= iInstruction;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_inc;
                        end
                    endcase
                end

                S_DELAY: begin
                    r_valid <= 1'b0;
                    r_count <= r_count - DELAY_WIDTH'(1);
                    if (r_count == DELAY_WIDTH'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end

                S_BRANCH: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_pc    <= iBranchTaken ? w_branch_target : w_pc_inc;
                    r_state <= S_FETCH;
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign oAddress     = r_pc;
    assign oInstruction = r_instr;
    assign oValid       = r_valid;
    assign oBusy        = r_busy;

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for instruction_sequencer. A behavioural ROM drives
// iInstruction from oAddress; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] LED = 4'd1;
    localparam logic [3:0] BLE = 4'd2;
    localparam logic [3:0] STO = 4'd3;
    localparam logic [3:0] ADD = 4'd4;
    localparam logic [3:0] JMP = 4'd5;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        iBranchTaken = 1'b0;
    logic        iStall = 1'b0;
    logic        oBusy;

    logic [27:0] rom [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress];

    instruction_sequencer #(
        .ADDR_WIDTH  (16),
        .DELAY_WIDTH (24)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oAddress     (oAddress),
        .iInstruction (iInstruction),
        .oInstruction (oInstruction),
        .oValid       (oValid),
        .iBranchTaken (iBranchTaken),
        .iStall       (iStall),
        .oBusy        (oBusy)
    );

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic fill_default();
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            a = 16'(i);
            rom[i] = mk(ADD, a[15:8], a[7:0], 8'h11);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  32'(oAddress), 32'h0);
        chk({tag, "_instr"}, 32'(oInstruction), 32'h0);
        chk({tag, "_valid"}, 32'(oValid), 32'h0);
        chk({tag, "_busy"},  32'(oBusy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        #1;
        check_zero("rst");
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Branch/jump trace: per-cycle expected valid, address, issued ROM index, busy.
    int exp_v [19] = '{0,1,1,0,1,1,0,1,1,0,1,1,0,1,1,1,1,0,1};
    int exp_a [19] = '{8,9,9,8,9,9,8,9,9,8,9,9,10,11,12,13,14,2,3};
    int exp_w [19] = '{-1,8,9,-1,8,9,-1,8,9,-1,8,9,-1,10,11,12,13,-1,2};
    int exp_b [19] = '{0,0,1,0,0,1,0,0,1,0,0,1,0,0,0,0,0,0,0};

    initial begin
        int n;
        int busy_cnt;
        int ble_n;
        bit found;
        bit addr_ok;

        // ---------------- NOP 4000 at address 0 ----------------
        fill_default();
        rom[0] = mk(NOP, 8'h00, 8'h0F, 8'hA0);   // N = 4000
        rom[1] = mk(ADD, 8'h01, 8'h02, 8'h03);
        do_reset();
        step();
        $display("nop issue: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("nop_valid", 32'(oValid), 32'h1);
        chk("nop_word",  32'(oInstruction), 32'(mk(NOP, 8'h00, 8'h0F, 8'hA0)));
        chk("nop_addr",  32'(oAddress), 32'h1);
        chk("nop_busy",  32'(oBusy), 32'h1);
        n = 0; busy_cnt = 1; found = 0; addr_ok = 1;
        while (!found && n < 5000) begin
            step();
            n++;
            if (oValid) found = 1;
            else begin
                if (oBusy) busy_cnt++;
                if (oAddress !== 16'h1) addr_ok = 0;
            end
        end
        $display("nop next issue after %0d cycles, busy %0d cycles", n, busy_cnt);
        chk("nop_latency",   32'(n), 32'd4001);
        chk("nop_busy_cnt",  32'(busy_cnt), 32'd4000);
        chk("nop_addr_hold", 32'(addr_ok), 32'h1);
        chk("nop_next_word", 32'(oInstruction), 32'(mk(ADD, 8'h01, 8'h02, 8'h03)));
        chk("nop_next_addr", 32'(oAddress), 32'h2);

        // ---------------- BLE loop and JMP ----------------
        fill_default();
        rom[0]  = mk(JMP, 8'h08, 8'h00, 8'h00);
        rom[8]  = mk(ADD, 8'h08, 8'h01, 8'h02);
        rom[9]  = mk(BLE, 8'h08, 8'h03, 8'h04);
        rom[10] = mk(STO, 8'h0A, 8'h00, 8'h01);
        rom[11] = mk(ADD, 8'h0B, 8'h00, 8'h02);
        rom[12] = mk(LED, 8'h0C, 8'h00, 8'h03);
        rom[13] = mk(ADD, 8'h0D, 8'h00, 8'h04);
        rom[14] = mk(JMP, 8'h02, 8'h00, 8'h00);
        rom[2]  = mk(LED, 8'h22, 8'h33, 8'h44);
        do_reset();
        ble_n = 0;
        for (int k = 0; k < 19; k++) begin
            step();
            $display("trace %0d: valid=%0b addr=%0h instr=%07h busy=%0b", k, oValid, oAddress, oInstruction, oBusy);
            chk($sformatf("br_valid_%0d", k), 32'(oValid), 32'(exp_v[k]));
            chk($sformatf("br_addr_%0d", k),  32'(oAddress), 32'(exp_a[k]));
            chk($sformatf("br_busy_%0d", k),  32'(oBusy), 32'(exp_b[k]));
            if (exp_w[k] >= 0)
                chk($sformatf("br_word_%0d", k), 32'(oInstruction), 32'(rom[exp_w[k]]));
            if (oValid && oInstruction[27:24] == BLE) begin
                ble_n++;
                iBranchTaken = (ble_n <= 3);
            end
        end

        // ---------------- Stall in FETCH, DELAY and BRANCH ----------------
        fill_default();
        rom[0]     = mk(ADD, 8'hA0, 8'h01, 8'h02);
        rom[1]     = mk(NOP, 8'h00, 8'h00, 8'h05);
        rom[2]     = mk(BLE, 8'h20, 8'h05, 8'h06);
        rom[16'h20] = mk(STO, 8'h20, 8'h07, 8'h08);
        do_reset();
        iStall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stf_valid_%0d", k), 32'(oValid), 32'h0);
            chk($sformatf("stf_addr_%0d", k),  32'(oAddress), 32'h0);
            chk($sformatf("stf_instr_%0d", k), 32'(oInstruction), 32'h0);
        end
        iStall = 1'b0;
        step();
        $display("stall fetch resume: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("stf_resume_word", 32'(oInstruction), 32'(rom[0]));
        chk("stf_resume_addr", 32'(oAddress), 32'h1);
        step();
        chk("std_nop_valid", 32'(oValid), 32'h1);
        chk("std_nop_word",  32'(oInstruction), 32'(rom[1]));
        step();
        step();                                  // counter now 3
        iStall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("std_valid_%0d", k), 32'(oValid), 32'h0);
            chk($sformatf("std_addr_%0d", k),  32'(oAddress), 32'h2);
            chk($sformatf("std_instr_%0d", k), 32'(oInstruction), 32'(rom[1]));
            chk($sformatf("std_busy_%0d", k),  32'(oBusy), 32'h1);
        end
        iStall = 1'b0;
        n = 0; found = 0;
        while (!found && n < 20) begin
            step();
            n++;
            if (oValid) found = 1;
        end
        $display("stall delay resume: ble issued %0d cycles after unstall", n);
        chk("std_resume_cycles", 32'(n), 32'd4);
        chk("stb_ble_word", 32'(oInstruction), 32'(rom[2]));
        chk("stb_ble_busy", 32'(oBusy), 32'h1);
        iBranchTaken = 1'b1;
        iStall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stb_valid_%0d", k), 32'(oValid), 32'h0);
            chk($sformatf("stb_addr_%0d", k),  32'(oAddress), 32'h2);
            chk($sformatf("stb_busy_%0d", k),  32'(oBusy), 32'h1);
        end
        iStall = 1'b0;
        step();
        chk("stb_taken_addr",  32'(oAddress), 32'h20);
        chk("stb_taken_valid", 32'(oValid), 32'h0);
        chk("stb_taken_busy",  32'(oBusy), 32'h0);
        step();
        $display("stall branch resume: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("stb_target_word", 32'(oInstruction), 32'(rom[16'h20]));
        chk("stb_target_addr", 32'(oAddress), 32'h21);

        // ---------------- Reset mid-NOP and mid-BRANCH ----------------
        fill_default();
        rom[0] = mk(NOP, 8'h00, 8'h04, 8'hD8);   // N = 1240
        do_reset();
        step();
        for (int k = 0; k < 6; k++) step();      // counter now 1234
        chk("rn_busy_before", 32'(oBusy), 32'h1);
        #2 Reset = 1'b1;
        #1;
        check_zero("rn_async");
        @(negedge Clock);
        Reset = 1'b0;
        step();
        $display("reset mid-nop resume: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("rn_first_valid", 32'(oValid), 32'h1);
        chk("rn_first_word",  32'(oInstruction), 32'(rom[0]));
        chk("rn_first_addr",  32'(oAddress), 32'h1);

        rom[0] = mk(BLE, 8'h05, 8'h01, 8'h02);
        do_reset();
        step();
        chk("rb_ble_busy", 32'(oBusy), 32'h1);
        #2 Reset = 1'b1;
        #1;
        check_zero("rb_async");
        @(negedge Clock);
        Reset = 1'b0;
        step();
        $display("reset mid-branch resume: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("rb_first_valid", 32'(oValid), 32'h1);
        chk("rb_first_word",  32'(oInstruction), 32'(rom[0]));
        chk("rb_first_addr",  32'(oAddress), 32'h0);

        // ---------------- PC wrap at 16'hFFFF ----------------
        fill_default();
        rom[16'hFFFF] = mk(STO, 8'hAB, 8'hCD, 8'hEF);
        do_reset();
        n = 0;
        while (oAddress != 16'hFFFF && n < 70000) begin
            step();
            n++;
        end
        chk("wrap_reach", 32'(oAddress), 32'hFFFF);
        chk("wrap_cycles", 32'(n), 32'd65535);
        step();
        $display("wrap issue: valid=%0b addr=%0h instr=%07h", oValid, oAddress, oInstruction);
        chk("wrap_valid", 32'(oValid), 32'h1);
        chk("wrap_word",  32'(oInstruction), 32'(mk(STO, 8'hAB, 8'hCD, 8'hEF)));
        chk("wrap_addr",  32'(oAddress), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program-flow controller for the MiniAlu core. It drives the address of the combinational instruction ROM and registers the fetched 28-bit word toward the execute datapath. It resolves the control opcodes itself:
- `NOP` delay counts
- `JMP` unconditional jumps
- `BLE` conditional branches, using a taken flag returned by the datapath

It sits between the ROM and the register-file/ALU datapath and replaces the free-running program counter.

## Interface
- `ADDR_WIDTH`, 16, width of ROM address and program counter.
- `DELAY_WIDTH`, 24, width of the `NOP` delay field and delay counter.
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `oAddress`  out  ADDR_WIDTH  ROM address, which is the current program counter.
- `iInstruction`  in  28  ROM word for `oAddress`, valid in the same cycle (combinational ROM).
- `oInstruction`  out  28  registered instruction issued to the datapath.
- `oValid`  out  1  `oInstruction` is new this cycle; the datapath executes exactly once per high cycle.
- `iBranchTaken`  in  1  datapath compare result for an issued `BLE`: 1 means src1 <= src0.
- `iStall`  in  1  datapath busy; freezes the sequencer.
- `oBusy`  out  1  high in DELAY or BRANCH state.

## Operation
- Instruction fields:
  - `[27:24]` opcode (encodings from the shared definitions header)
  - `[23:16]` destination or branch target
  - `[15:8]` src1
  - `[7:0]` src0
  - For `NOP`, `[23:0]` is the delay count N.
- States: FETCH, DELAY, BRANCH.
- Reset values:
  - state = FETCH
  - `oAddress` = 0
  - `oInstruction` = 0
  - `oValid` = 0
  - delay counter = 0
  - `oBusy` = 0
- FETCH, on each edge with `iStall` = 0, decode `iInstruction`:
  - `NOP`, N = 0: issue it (`oInstruction` <= word, `oValid` <= 1); PC <= PC+1; stay in FETCH.
  - `NOP`, N > 0: issue it; PC <= PC+1; counter <= N; go to DELAY.
  - `JMP`: not issued (`oValid` <= 0); PC <= {8'b0, `[23:16]`}; stay in FETCH.
  - `BLE`: issue it (`oValid` <= 1); PC unchanged; go to BRANCH.
  - Any other opcode (ALU, `STO`, `LED`, unknown): issue it; PC <= PC+1; stay in FETCH.
- DELAY: `oValid` <= 0. Each unstalled edge decrements the counter. At the edge where the counter is 1, go to FETCH with the counter reaching 0.
- BRANCH: `oValid` <= 0. At the next unstalled edge, sample `iBranchTaken`:
  - taken: PC <= zero-extended `[23:16]`
  - not taken: PC <= PC+1
  - Then go to FETCH.
- The datapath drives `iBranchTaken` combinationally while it holds the issued `BLE`. It must keep the value stable while `iStall` = 1.
- Stall: any edge with `iStall` = 1 leaves state, PC, counter and `oInstruction` unchanged and forces `oValid` <= 0. No instruction is lost or issued twice.
- PC arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF + 1 wraps to 0.
- Jump and branch targets are 8 bits, zero-extended. Addresses above 255 are reachable only sequentially.
- Asserting `Reset` in any state, including mid-delay or mid-branch, returns all outputs to their reset values asynchronously. After release, fetch restarts at address 0.

## Timing
- Issue latency: the ROM word at PC appears on `oInstruction` with `oValid` = 1 one cycle after the FETCH edge.
- Throughput with no stalls:
  - ALU/`STO`/`LED`: 1 cycle each, back to back.
  - `JMP`: 1 cycle, no issue bubble beyond itself.
  - `BLE`: 2 cycles.
  - `NOP` N: 1+N cycles.
- `oValid` is never high for two consecutive cycles carrying the same fetch.
- `oBusy` is registered; it is high exactly in the cycles the state is DELAY or BRANCH.
- `iStall` and `iBranchTaken` are sampled only at rising edges; there are no combinational paths from them to outputs.

## Test plan
- Reset, then `NOP` 24'd4000 at address 0:
  - `oValid` high for 1 cycle with the `NOP` word.
  - `oAddress` = 1 from that cycle on.
  - Next issue (address 1) appears exactly 4001 cycles after the first issue.
  - `oBusy` is high for 4000 cycles.
- ROM 8: `ADD`, ROM 9: `BLE` target 8:
  - With `iBranchTaken` = 1 three times then 0: issue sequence is 8,9,8,9,8,9,8,9,10.
  - Each `BLE` is followed by one `oValid` = 0 cycle.
- `JMP` 8'd2 at address 14: `oAddress` goes 14 then 2; `oValid` = 0 for the `JMP` cycle; the word at 2 issues next.
- `iStall` held 5 cycles, asserted in turn during FETCH, DELAY (counter = 3) and BRANCH:
  - PC, counter and `oInstruction` are frozen.
  - `oValid` = 0.
  - Resumption matches the unstalled trace shifted by 5.
- `Reset` pulsed mid-`NOP` (counter = 1234) and mid-BRANCH: outputs go to 0 immediately; the first issue after release is address 0.
- PC = 16'hFFFF with a non-control word: issues it, then `oAddress` = 0.
